alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; all datapaths SHALL be fixed at 8 bits with a 3-bit operation select.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid[1:0]  input  2  per-requester operation request.
REQ-005 req_ready[1:0]  output  2  per-requester accept; at most one bit high in any cycle.
REQ-006 req_a0, req_b0, req_a1, req_b1  input  8 each  operands for requester 0 and 1.
REQ-007 req_sel0, req_sel1  input  3 each  operation select for requester 0 and 1; same encoding as the ALU.
REQ-008 rsp_valid[1:0]  output  2  per-requester result valid; at most one bit high.
REQ-009 rsp_ready[1:0]  input  2  per-requester result accept.
REQ-010 rsp_out  output  8  result, shared by both requesters.
REQ-011 rsp_carry  output  1  carry/borrow, shared by both requesters.
REQ-012 alu_a, alu_b  output  8 each  operands driven to the external combinational ALU.
REQ-013 alu_sel  output  3  select driven to the ALU.
REQ-014 alu_out  input  8  ALU result.
REQ-015 alu_carry  input  1  ALU carry output.

Function
REQ-016 FSM SHALL have states IDLE, EXEC and RESP; one operation SHALL be in flight at a time.
REQ-017 IDLE: if any req_valid is high, req_ready SHALL assert combinationally for the granted requester only; all req_ready SHALL be low in EXEC and RESP.
REQ-018 On req_valid&req_ready at edge N: the granted requester's a, b and sel SHALL be captured into operand registers, the owner index SHALL be recorded, and the FSM SHALL go to EXEC.
REQ-019 alu_a/alu_b/alu_sel SHALL be driven from the operand registers in every state; they SHALL change only on capture.
REQ-020 EXEC: at edge N+1, alu_out SHALL be registered into rsp_out and the FSM SHALL go to RESP.
REQ-021 rsp_carry SHALL register alu_carry only when sel is 3'b000 or 3'b001; for every other sel it SHALL register 0.
REQ-022 RESP: rsp_valid[owner] SHALL be high from after edge N+1 until rsp_ready[owner] is sampled high; rsp_out and rsp_carry SHALL be held stable meanwhile.
REQ-023 rsp_ready for the non-owner SHALL be ignored.
REQ-024 On the rsp handshake edge the FSM SHALL return to IDLE; a new grant SHALL be possible in the following cycle, giving minimum throughput of 1 op / 3 cycles.
REQ-025 Minimum request-to-response latency SHALL be 2 edges (accept edge N, rsp_valid visible after N+1).
REQ-026 Requesters SHALL hold req_valid and their operands until accepted; operand changes while waiting SHALL NOT corrupt an in-flight operation.
REQ-027 Grant policy SHALL follow REQ-031/REQ-032; a request from a single requester SHALL always be granted in IDLE.

Reset
REQ-028 While rst_n is low: FSM = IDLE, req_ready = 0, rsp_valid = 0, rsp_out = 0, rsp_carry = 0, operand registers = 0 (alu_a = alu_b = 0, alu_sel = 0), owner = 0, round-robin pointer = 0.
REQ-029 Reset asserted mid-operation SHALL abort it immediately; no response for the aborted operation SHALL ever be issued.
REQ-030 After deassertion the first grant SHALL be possible in the first cycle after the first rising edge.

Configuration
REQ-031 Macro ALU_ARB_RR_EN defined: round-robin grant; a pointer SHALL name the preferred requester and, on each completed rsp handshake, SHALL move to the requester other than the one just served; on simultaneous requests the preferred requester SHALL win.
REQ-032 ALU_ARB_RR_EN undefined: fixed priority, requester 0 SHALL always win simultaneous requests; the pointer logic SHALL be absent.

Verification
REQ-033 Reset, then req0: a=8'd200, b=8'd100, sel=000 -> accept at edge N, rsp_valid[0] after N+1, rsp_out=8'd44, rsp_carry=1.
REQ-034 req1: a=8'h0F, b=8'hF0, sel=100 -> rsp_out=8'hFF, rsp_carry=0; req1: a=8'd5, b=8'd5, sel=111 -> rsp_out=8'd1.
REQ-035 Both requesters valid continuously, with ALU_ARB_RR_EN defined -> grants alternate 0,1,0,1; without it -> four consecutive grants to requester 0.
REQ-036 rsp_ready held low 5 cycles in RESP while the other requester is valid -> rsp_out stable, no req_ready asserted, grant only after the rsp handshake.
REQ-037 rst_n pulsed low during EXEC of a=8'd3, b=8'd5, sel=001 -> all outputs 0 immediately, and no rsp_valid for that operation after release.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end sharing one external combinational ALU.
// Define ALU_ARB_RR_EN for round-robin grant; otherwise requester 0 has fixed priority.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req_a0,
    input  logic [7:0] req_b0,
    input  logic [7:0] req_a1,
    input  logic [7:0] req_b1,
    input  logic [2:0] req_sel0,
    input  logic [2:0] req_sel1,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [7:0] rsp_out,
    output logic       rsp_carry,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [2:0] sel_q, sel_d;
    logic       owner_q, owner_d;
    logic [7:0] out_q, out_d;
    logic       carry_q, carry_d;

    logic [1:0] grant;
    logic       grant_idx;
    logic       rsp_hs;
    logic       carry_op;

`ifdef ALU_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Prefer the requester that was not just served.
    always_comb begin
        ptr_d = ptr_q;
        if (rsp_hs) begin
            ptr_d = ~owner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant = 2'b00;
        if (req_valid[0]) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end
    end
`endif

    assign grant_idx = grant[1];
    assign rsp_hs    = (state_q == RESP) && rsp_ready[owner_q];
    assign carry_op  = (sel_q[2:1] == 2'b00);

    // Gated by rst_n so no accept is offered while reset is held.
    assign req_ready = (state_q == IDLE && rst_n) ? grant : 2'b00;
    assign rsp_valid = (state_q == RESP) ? {owner_q, ~owner_q} : 2'b00;

    assign rsp_out   = out_q;
    assign rsp_carry = carry_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        owner_d = owner_q;
        out_d   = out_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    a_d     = grant_idx ? req_a1 : req_a0;
                    b_d     = grant_idx ? req_b1 : req_b0;
                    sel_d   = grant_idx ? req_sel1 : req_sel0;
                    owner_d = grant_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_d   = alu_out;
                carry_d = carry_op ? alu_carry : 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            sel_q   <= 3'd0;
            owner_q <= 1'b0;
            out_q   <= 8'd0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            owner_q <= owner_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter
// against a transaction-level reference model and a behavioural ALU.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0] req_a [2];
    logic [7:0] req_b [2];
    logic [2:0] req_sel [2];
    logic [7:0] rsp_out, alu_a, alu_b, alu_out;
    logic       rsp_carry, alu_carry;
    logic [2:0] alu_sel;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a[0]), .req_b0(req_b[0]),
        .req_a1(req_a[1]), .req_b1(req_b[1]),
        .req_sel0(req_sel[0]), .req_sel1(req_sel[1]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_carry(rsp_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry)
    );

    // External ALU; logical ops drive carry high so gating is observable.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] s);
        case (s)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {a < b, a - b};
            3'd2: return {1'b1, a & b};
            3'd3: return {1'b1, a ^ b};
            3'd4: return {1'b1, a | b};
            3'd5: return {1'b1, ~a};
            3'd6: return {1'b1, a << 1};
            default: return {1'b1, 7'd0, a == b};
        endcase
    endfunction

    always_comb {alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);

    function automatic logic [1:0] arb(input logic [1:0] v, input bit p);
        if (v != 2'b11) return v;
`ifdef ALU_ARB_RR_EN
        return p ? 2'b10 : 2'b01;
`else
        return (p && 1'b0) ? 2'b10 : 2'b01;
`endif
    endfunction

    // Reference model: one transaction in flight, result due one edge after accept.
    bit         m_busy, m_owner, m_ptr;
    int         m_age;
    logic [7:0] m_a, m_b, m_out, pend_out;
    logic [2:0] m_sel;
    logic       m_carry, pend_c;
    int         acc_idx;
    logic [1:0] dut_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0;
        m_a = 0; m_b = 0; m_sel = 0; m_out = 0; m_carry = 0;
        pend_out = 0; pend_c = 0; acc_idx = -1;
    endtask

    task automatic model_update();
        logic [1:0] g;
        logic [8:0] r;
        int i;
        acc_idx = -1;
        if (!rst_n) return;
        if (!m_busy) begin
            g = arb(req_valid, m_ptr);
            if (g != 2'b00) begin
                i = g[1] ? 1 : 0;
                m_a = req_a[i]; m_b = req_b[i]; m_sel = req_sel[i];
                r = alu_f(m_a, m_b, m_sel);
                pend_out = r[7:0];
                pend_c = (m_sel < 3'd2) ? r[8] : 1'b0;
                m_owner = g[1]; m_busy = 1; m_age = 0; acc_idx = i;
            end
        end else if (m_age == 0) begin
            m_age = 1; m_out = pend_out; m_carry = pend_c;
        end else if (rsp_ready[m_owner]) begin
            m_busy = 0; m_ptr = !m_owner;
        end
    endtask

    task automatic check_cycle();
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_out", 32'(rsp_out), 0);
            chk("rst_rsp_carry", 32'(rsp_carry), 0);
            chk("rst_alu_ops", {alu_sel, alu_a, alu_b}, 0);
            return;
        end
        chk("alu_ops", {alu_sel, alu_a, alu_b}, {m_sel, m_a, m_b});
        if (!m_busy) begin
            chk("grant", 32'(req_ready), 32'(arb(req_valid, m_ptr)));
            chk("idle_rsp_valid", 32'(rsp_valid), 0);
        end else begin
            chk("busy_req_ready", 32'(req_ready), 0);
            chk("rsp_valid", 32'(rsp_valid), (m_age == 0) ? 0 : (m_owner ? 2 : 1));
        end
        if (!(m_busy && m_age == 0)) begin
            chk("rsp_out", 32'(rsp_out), 32'(m_out));
            chk("rsp_carry", 32'(rsp_carry), 32'(m_carry));
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        dut_acc = req_ready & req_valid;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s, input logic [7:0] eo, input logic ec,
                         input string tag);
        req_valid[idx] = 1'b1;
        req_a[idx] = a; req_b[idx] = b; req_sel[idx] = s;
        step();
        chk({tag, "_accept"}, 32'(acc_idx), 32'(idx));
        req_valid[idx] = 1'b0;
        req_a[idx] = ~a; req_b[idx] = ~b; req_sel[idx] = ~s;
        step();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << idx));
        chk({tag, "_rsp_out"}, 32'(rsp_out), 32'(eo));
        chk({tag, "_rsp_carry"}, 32'(rsp_carry), 32'(ec));
        rsp_ready[idx] = 1'b1;
        step();
        rsp_ready = 2'b00;
    endtask

    initial begin
        int g [4];
        int n, cnt;
        model_reset();
        rst_n = 1'b0;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_a[i] = 8'h5A; req_b[i] = 8'hA5; req_sel[i] = 3'd0;
        end
        repeat (3) step();
        req_valid = 2'b00; rsp_ready = 2'b00;
        rst_n = 1'b1;

        do_op(0, 8'd200, 8'd100, 3'b000, 8'd44, 1'b1, "r033");
        do_op(1, 8'h0F, 8'hF0, 3'b100, 8'hFF, 1'b0, "r034_or");
        do_op(1, 8'd5, 8'd5, 3'b111, 8'd1, 1'b0, "r034_eq");

        // Held response with the other requester waiting.
        req_valid[0] = 1'b1; req_a[0] = 8'h12; req_b[0] = 8'h34; req_sel[0] = 3'd2;
        step();
        req_valid[0] = 1'b0;
        step();
        req_valid[1] = 1'b1; req_a[1] = 8'h80; req_b[1] = 8'h80; req_sel[1] = 3'd0;
        rsp_ready = 2'b10;
        repeat (5) begin
            step();
            chk("r036_hold", 32'(rsp_out), 32'h10);
            chk("r036_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("r036_no_ready", 32'(req_ready), 0);
        end
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        chk("r036_grant_after", 32'(req_ready), 32'h2);
        step();
        chk("r036_accept1", 32'(acc_idx), 1);
        req_valid[1] = 1'b0;
        step();
        chk("r036_out1", 32'(rsp_out), 0);
        chk("r036_carry1", 32'(rsp_carry), 1);
        rsp_ready[1] = 1'b1;
        step();
        rsp_ready = 2'b00;

        // Both requesters continuously valid.
        req_valid = 2'b11; rsp_ready = 2'b11;
        n = 0; cnt = 0;
        while (n < 4 && cnt < 40) begin
            step();
            if (dut_acc != 2'b00) begin
                g[n] = dut_acc[1] ? 1 : 0;
                n++;
            end
            cnt++;
        end
        req_valid = 2'b00;
        cnt = 0;
        while (m_busy && cnt < 10) begin
            step();
            cnt++;
        end
        rsp_ready = 2'b00;
        chk("r035_count", 32'(n), 4);
        for (int k = 0; k < n; k++) begin
`ifdef ALU_ARB_RR_EN
            chk("r035_grant", 32'(g[k]), 32'(k % 2));
`else
            chk("r035_grant", 32'(g[k]), 0);
`endif
        end

        // Reset in the middle of an operation.
        req_valid[0] = 1'b1; req_a[0] = 8'd3; req_b[0] = 8'd5; req_sel[0] = 3'b001;
        step();
        chk("r037_accept", 32'(acc_idx), 0);
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("r037_req_ready", 32'(req_ready), 0);
        chk("r037_rsp_valid", 32'(rsp_valid), 0);
        chk("r037_rsp_out", 32'(rsp_out), 0);
        chk("r037_rsp_carry", 32'(rsp_carry), 0);
        chk("r037_alu_ops", {alu_sel, alu_a, alu_b}, 0);
        step();
        step();
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        repeat (4) begin
            step();
            chk("r037_no_rsp", 32'(rsp_valid), 0);
        end
        rsp_ready = 2'b00;

        // Randomized traffic, with one reset partway through.
        for (int c = 0; c < 800; c++) begin
            step();
            if (c == 400) begin
                rst_n = 1'b0;
                model_reset();
                step();
                step();
                rst_n = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (acc_idx == i || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    req_a[i] = 8'($urandom);
                    req_b[i] = 8'($urandom);
                    req_sel[i] = 3'($urandom);
                end
            end
            rsp_ready = 2'($urandom);
        end
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
